render_write_fifo: RTL and testbench

Elastic write buffer between render_module and framebuffer_module. It absorbs bursts of pixel writes (coords + palette colour) from the renderer and drains them to the framebuffer write port whenever the framebuffer can accept them. It also enforces a frame barrier: the renderer's done is forwarded only after every buffered pixel has been written. The done/ack pair is relayed in both directions.

---
 rtl/render_write_fifo.sv | 213 +++++++++++++++++++++
 tb/tb_render_write_fifo.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/render_write_fifo.sv
// ---------------------------------------------------------------------------
// render_write_fifo
//
// Elastic write buffer between the renderer and the framebuffer write port.
// Pixel writes (packed screen coordinates + palette colour) are queued in a
// circular buffer and presented show-ahead to the framebuffer. A frame
// barrier holds back the renderer's done until every buffered pixel has been
// written, and the done/ack handshake is relayed in both directions.
//
// Ports
//   Clk             system clock
//   Reset           asynchronous, active-high reset
//   in_valid        renderer presents a pixel write
//   in_coords       pixel coordinates {x[8:0], y[7:0]}
//   in_color        pixel colour
//   in_ready        write accepted this cycle (FILL state and not full)
//   render_done_in  renderer finished frame (level, held until acked)
//   render_ack_out  one-cycle ack back to the renderer
//   fb_we           write strobe to framebuffer (FIFO not empty)
//   fb_coords       head-of-FIFO coordinates
//   fb_color        head-of-FIFO colour
//   fb_ready        framebuffer consumes the write this cycle
//   fb_render_done  drained-done to framebuffer
//   fb_render_ack   framebuffer accepted done / swapped buffers
//   occupancy       current entry count
//   high_water      max occupancy since the last frame ack
// ---------------------------------------------------------------------------
module render_write_fifo #(
    parameter int XY_W    = 17,
    parameter int COLOR_W = 8,
    parameter int DEPTH   = 16,
    parameter int CNT_W   = 5
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               in_valid,
    input  logic [XY_W-1:0]    in_coords,
    input  logic [COLOR_W-1:0] in_color,
    output logic               in_ready,
    input  logic               render_done_in,
    output logic               render_ack_out,
    output logic               fb_we,
    output logic [XY_W-1:0]    fb_coords,
    output logic [COLOR_W-1:0] fb_color,
    input  logic               fb_ready,
    output logic               fb_render_done,
    input  logic               fb_render_ack,
    output logic [CNT_W-1:0]   occupancy,
    output logic [CNT_W-1:0]   high_water
);

    localparam int PTR_W = CNT_W - 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t               state_r;
    state_t               state_nxt_s;
    logic [PTR_W-1:0]     wr_ptr_r;
    logic [PTR_W-1:0]     rd_ptr_r;
    logic [CNT_W-1:0]     occ_r;
    logic [CNT_W-1:0]     occ_nxt_s;
    logic [CNT_W-1:0]     hw_r;
    logic                 rearm_r;
    logic                 ack_out_r;
    logic                 ack_fire_s;
    logic                 barrier_s;
    logic                 in_ready_s;
    logic                 fb_we_s;
    logic                 push_s;
    logic                 pop_s;

    logic [XY_W-1:0]      coords_mem_r [DEPTH];
    logic [COLOR_W-1:0]   color_mem_r  [DEPTH];

    // Handshake qualifiers. in_ready is forced low while Reset is asserted,
    // since the reset state itself (FILL, empty) would otherwise accept.
    // It deliberately ignores a same-cycle pop: a full FIFO refuses writes.
    assign in_ready_s = (!Reset) && (state_r == ST_FILL) && (occ_r != FULL_CNT);
    assign fb_we_s    = (occ_r != {CNT_W{1'b0}}) && (state_r != ST_DONE);
    assign push_s     = in_valid && in_ready_s;
    assign pop_s      = fb_we_s && fb_ready;

    // The barrier triggers only once the renderer has dropped done since the
    // last ack, so a done still held high from the previous frame is ignored.
    assign barrier_s  = (state_r == ST_FILL) && render_done_in && rearm_r;

    // Next occupancy: simultaneous push and pop leaves the count unchanged.
    always_comb begin
        occ_nxt_s = occ_r;
        case ({push_s, pop_s})
            2'b10:   occ_nxt_s = occ_r + CNT_ONE;
            2'b01:   occ_nxt_s = occ_r - CNT_ONE;
            default: occ_nxt_s = occ_r;
        endcase
    end

    // Frame-barrier next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        ack_fire_s  = 1'b0;
        case (state_r)
            ST_FILL: begin
                if (barrier_s) begin
                    state_nxt_s = ST_DRAIN;
                end else begin
                    state_nxt_s = ST_FILL;
                end
            end
            ST_DRAIN: begin
                // Empty means fb_we is low, so no pop can still be pending.
                if (occ_r == {CNT_W{1'b0}}) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            ST_DONE: begin
                if (fb_render_ack) begin
                    state_nxt_s = ST_FILL;
                    ack_fire_s  = 1'b1;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            default: begin
                state_nxt_s = ST_FILL;
            end
        endcase
    end

    // State register.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_r <= ST_FILL;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Pointers and occupancy; pointers wrap naturally at DEPTH (power of two).
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            occ_r    <= {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            occ_r <= occ_nxt_s;
        end
    end

    // High-water mark tracks the peak occupancy of the current frame.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            hw_r <= {CNT_W{1'b0}};
        end else if (ack_fire_s) begin
            hw_r <= {CNT_W{1'b0}};
        end else if (occ_nxt_s > hw_r) begin
            hw_r <= occ_nxt_s;
        end
    end

    // Rearm flag: cleared when the barrier fires, set again once done has
    // been seen low while accepting writes.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            rearm_r <= 1'b1;
        end else if (barrier_s) begin
            rearm_r <= 1'b0;
        end else if ((state_r == ST_FILL) && !render_done_in) begin
            rearm_r <= 1'b1;
        end
    end

    // One-cycle ack to the renderer, the cycle after the framebuffer acks.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            ack_out_r <= 1'b0;
        end else begin
            ack_out_r <= ack_fire_s;
        end
    end

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge Clk) begin
        if (push_s) begin
            coords_mem_r[wr_ptr_r] <= in_coords;
            color_mem_r[wr_ptr_r]  <= in_color;
        end
    end

    assign in_ready       = in_ready_s;
    assign fb_we          = fb_we_s;
    assign fb_coords      = coords_mem_r[rd_ptr_r];
    assign fb_color       = color_mem_r[rd_ptr_r];
    assign fb_render_done = (state_r == ST_DONE);
    assign render_ack_out = ack_out_r;
    assign occupancy      = occ_r;
    assign high_water     = hw_r;

endmodule

// File: tb/tb_render_write_fifo.sv
// ---------------------------------------------------------------------------
// tb_render_write_fifo
//
// Directed bench for render_write_fifo. Inputs change 1 time unit after the
// rising edge; outputs are sampled at that same point, i.e. they reflect the
// state registered at the preceding edge. Every expected value is written
// out by hand from the intended behaviour.
// ---------------------------------------------------------------------------
module tb_render_write_fifo;

    logic        Clk;
    logic        Reset;
    logic        in_valid;
    logic [16:0] in_coords;
    logic [7:0]  in_color;
    logic        in_ready;
    logic        render_done_in;
    logic        render_ack_out;
    logic        fb_we;
    logic [16:0] fb_coords;
    logic [7:0]  fb_color;
    logic        fb_ready;
    logic        fb_render_done;
    logic        fb_render_ack;
    logic [4:0]  occupancy;
    logic [4:0]  high_water;

    int vectors;
    int miscompares;

    render_write_fifo #(
        .XY_W    (17),
        .COLOR_W (8),
        .DEPTH   (16),
        .CNT_W   (5)
    ) dut (
        .Clk            (Clk),
        .Reset          (Reset),
        .in_valid       (in_valid),
        .in_coords      (in_coords),
        .in_color       (in_color),
        .in_ready       (in_ready),
        .render_done_in (render_done_in),
        .render_ack_out (render_ack_out),
        .fb_we          (fb_we),
        .fb_coords      (fb_coords),
        .fb_color       (fb_color),
        .fb_ready       (fb_ready),
        .fb_render_done (fb_render_done),
        .fb_render_ack  (fb_render_ack),
        .occupancy      (occupancy),
        .high_water     (high_water)
    );

    // 10-unit clock.
    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // Run-time bound.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        vectors        = 0;
        miscompares    = 0;
        Reset          = 1'b1;
        in_valid       = 1'b0;
        in_coords      = 17'h00000;
        in_color       = 8'h00;
        render_done_in = 1'b0;
        fb_ready       = 1'b0;
        fb_render_ack  = 1'b0;

        // ---- reset state ----
        #2;
        chk("rst_in_ready",   32'(in_ready),       32'd0);
        chk("rst_fb_we",      32'(fb_we),          32'd0);
        chk("rst_occ",        32'(occupancy),      32'd0);
        chk("rst_hw",         32'(high_water),     32'd0);
        chk("rst_fb_done",    32'(fb_render_done), 32'd0);
        chk("rst_ack_out",    32'(render_ack_out), 32'd0);
        tick();
        Reset = 1'b0;
        #1;
        chk("rel_in_ready",   32'(in_ready),       32'd1);

        // ---- three back-to-back pushes, fb_ready high ----
        fb_ready  = 1'b1;
        in_valid  = 1'b1;
        in_coords = 17'h00001;
        in_color  = 8'h11;
        tick();
        chk("bb1_we",     32'(fb_we),     32'd1);
        chk("bb1_coords", 32'(fb_coords), 32'h00001);
        chk("bb1_color",  32'(fb_color),  32'h11);
        chk("bb1_occ",    32'(occupancy), 32'd1);
        in_coords = 17'h00002;
        in_color  = 8'h22;
        tick();
        chk("bb2_coords", 32'(fb_coords), 32'h00002);
        chk("bb2_occ",    32'(occupancy), 32'd1);
        in_coords = 17'h00003;
        in_color  = 8'h33;
        tick();
        chk("bb3_coords", 32'(fb_coords), 32'h00003);
        chk("bb3_color",  32'(fb_color),  32'h33);
        in_valid = 1'b0;
        tick();
        chk("bb_end_we",  32'(fb_we),      32'd0);
        chk("bb_end_occ", 32'(occupancy),  32'd0);
        chk("bb_end_hw",  32'(high_water), 32'd1);

        // ---- fill to full with fb_ready low (pointers wrap from 3) ----
        fb_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            in_valid  = 1'b1;
            in_coords = 17'(32'h100 + i);
            in_color  = 8'(i);
            chk("fill_rdy", 32'(in_ready),  32'd1);
            chk("fill_occ", 32'(occupancy), 32'(i));
            tick();
        end
        in_coords = 17'h00110;
        in_color  = 8'd16;
        chk("full_occ",    32'(occupancy), 32'd16);
        chk("full_rdy",    32'(in_ready),  32'd0);
        chk("full_we",     32'(fb_we),     32'd1);
        chk("full_head",   32'(fb_coords), 32'h00100);
        tick();
        chk("full_hold",   32'(occupancy), 32'd16);
        chk("full_hold_h", 32'(fb_coords), 32'h00100);

        // Pop while full with in_valid high: push refused this cycle.
        fb_ready = 1'b1;
        tick();
        chk("popfull_occ",  32'(occupancy), 32'd15);
        chk("popfull_rdy",  32'(in_ready),  32'd1);
        chk("popfull_head", 32'(fb_coords), 32'h00101);
        tick();
        in_valid = 1'b0;
        for (int k = 2; k <= 16; k++) begin
            chk("drain_coords", 32'(fb_coords), 32'(32'h100 + k));
            chk("drain_color",  32'(fb_color),  32'(k));
            chk("drain_occ",    32'(occupancy), 32'(17 - k));
            tick();
        end
        chk("drain_end_occ", 32'(occupancy),  32'd0);
        chk("drain_end_we",  32'(fb_we),      32'd0);
        chk("drain_end_hw",  32'(high_water), 32'd16);

        // ---- frame barrier with 5 entries and toggling fb_ready ----
        fb_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid  = 1'b1;
            in_coords = 17'(32'h200 + i);
            in_color  = 8'(32'hA0 + i);
            tick();
        end
        in_valid       = 1'b0;
        render_done_in = 1'b1;
        tick();
        chk("bar_rdy",  32'(in_ready),       32'd0);
        chk("bar_occ",  32'(occupancy),      32'd5);
        chk("bar_done", 32'(fb_render_done), 32'd0);
        for (int j = 0; j < 12; j++) begin
            fb_ready = ((j % 2) == 1);
            if ((j % 2) == 1 && j < 10) begin
                chk("bar_pop_coords", 32'(fb_coords), 32'(32'h200 + j / 2));
                chk("bar_pop_color",  32'(fb_color),  32'(32'hA0 + j / 2));
            end
            tick();
            chk("bar_done_j", 32'(fb_render_done), 32'(j >= 10));
            chk("bar_occ_j",  32'(occupancy),      32'((j >= 9) ? 0 : 5 - (j + 1) / 2));
        end
        fb_ready = 1'b0;
        chk("done_we", 32'(fb_we),      32'd0);
        chk("done_hw", 32'(high_water), 32'd16);
        fb_render_ack = 1'b1;
        tick();
        fb_render_ack = 1'b0;
        chk("ack_pulse",  32'(render_ack_out), 32'd1);
        chk("ack_hw",     32'(high_water),     32'd0);
        chk("ack_rdy",    32'(in_ready),       32'd1);
        chk("ack_done",   32'(fb_render_done), 32'd0);
        tick();
        chk("ack_pulse_end", 32'(render_ack_out), 32'd0);

        // ---- done held high through the ack must not retrigger ----
        tick();
        tick();
        chk("held_done", 32'(fb_render_done), 32'd0);
        chk("held_rdy",  32'(in_ready),       32'd1);
        render_done_in = 1'b0;
        tick();
        render_done_in = 1'b1;
        tick();
        chk("rearm_drain_rdy", 32'(in_ready),       32'd0);
        tick();
        chk("rearm_done",      32'(fb_render_done), 32'd1);
        fb_render_ack  = 1'b1;
        render_done_in = 1'b0;
        tick();
        fb_render_ack = 1'b0;
        chk("rearm_ack",       32'(render_ack_out), 32'd1);

        // ---- fb_render_ack outside DONE is ignored ----
        tick();
        fb_render_ack = 1'b1;
        tick();
        fb_render_ack = 1'b0;
        chk("stray_ack",     32'(render_ack_out), 32'd0);
        chk("stray_ack_rdy", 32'(in_ready),       32'd1);
        chk("stray_ack_dn",  32'(fb_render_done), 32'd0);

        // ---- asynchronous reset mid-DRAIN with 7 entries ----
        fb_ready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            in_valid  = 1'b1;
            in_coords = 17'(32'h300 + i);
            in_color  = 8'(i);
            tick();
        end
        in_valid       = 1'b0;
        render_done_in = 1'b1;
        tick();
        chk("pre_rst_occ", 32'(occupancy), 32'd7);
        chk("pre_rst_rdy", 32'(in_ready),  32'd0);
        #2;
        Reset = 1'b1;
        #1;
        chk("arst_occ",  32'(occupancy),      32'd0);
        chk("arst_we",   32'(fb_we),          32'd0);
        chk("arst_done", 32'(fb_render_done), 32'd0);
        chk("arst_rdy",  32'(in_ready),       32'd0);
        chk("arst_hw",   32'(high_water),     32'd0);
        render_done_in = 1'b0;
        tick();
        Reset     = 1'b0;
        fb_ready  = 1'b1;
        in_valid  = 1'b1;
        in_coords = 17'h003AB;
        in_color  = 8'h5C;
        tick();
        in_valid = 1'b0;
        chk("post_we",     32'(fb_we),     32'd1);
        chk("post_coords", 32'(fb_coords), 32'h003AB);
        chk("post_color",  32'(fb_color),  32'h5C);
        chk("post_occ",    32'(occupancy), 32'd1);
        tick();
        chk("post_occ0",   32'(occupancy),  32'd0);
        chk("post_hw",     32'(high_water), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
